// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: EX/MEM fields -> req/ready bus access -> MEM/WB result.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_dmem_ctrl #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [XLEN-1:0] alu_result_in,
   input  logic [XLEN-1:0] rs2_val_in,
   input  logic            reg_write_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic [4:0]      rd_idx_in,
   output logic            mem_stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            valid_out,
   output logic [XLEN-1:0] wb_data_out,
   output logic            reg_write_out,
   output logic [4:0]      rd_idx_out,
   output logic            mem_err
);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q, we_d;
   logic [4:0]      rd_q, rd_d;
   logic            rw_q, rw_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] wb_q, wb_d;
   logic            rw_out_q, rw_out_d;
   logic [4:0]      rd_out_q, rd_out_d;
   logic            err_q, err_d;
   logic            stall;
   logic            mem_op;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   assign mem_op = valid_in & (mem_read_in | mem_write_in);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rd_d     = rd_q;
      rw_d     = rw_q;
      valid_d  = 1'b0;
      wb_d     = wb_q;
      rw_out_d = rw_out_q;
      rd_out_d = rd_out_q;
      err_d    = 1'b0;
      stall    = 1'b0;
      dmem_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (mem_op) begin
               stall   = 1'b1;
               addr_d  = {alu_result_in[XLEN-1:2], 2'b00};
               wdata_d = rs2_val_in;
               // Read+write together is treated as a store.
               we_d    = mem_write_in;
               rd_d    = rd_idx_in;
               rw_d    = reg_write_in & ~mem_write_in & (rd_idx_in != 5'd0);
               state_d = StAccess;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else if (valid_in) begin
               valid_d  = 1'b1;
               wb_d     = alu_result_in;
               rw_out_d = reg_write_in & (rd_idx_in != 5'd0);
               rd_out_d = rd_idx_in;
            end
         end
         StAccess: begin
            dmem_req = 1'b1;
            stall    = ~dmem_ready;
            if (dmem_ready) begin
               state_d  = StIdle;
               valid_d  = 1'b1;
               wb_d     = we_q ? addr_q : dmem_rdata;
               rw_out_d = rw_q;
               rd_out_d = rd_q;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               // Abort: release the pipeline and retire a null result flagged as an error.
               state_d  = StIdle;
               stall    = 1'b0;
               valid_d  = 1'b1;
               wb_d     = '0;
               rw_out_d = 1'b0;
               rd_out_d = rd_q;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rd_q     <= '0;
         rw_q     <= 1'b0;
         valid_q  <= 1'b0;
         wb_q     <= '0;
         rw_out_q <= 1'b0;
         rd_out_q <= '0;
         err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         rw_q     <= rw_d;
         valid_q  <= valid_d;
         wb_q     <= wb_d;
         rw_out_q <= rw_out_d;
         rd_out_q <= rd_out_d;
         err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Gated by reset so the stall drops immediately while reset is held.
   assign mem_stall     = stall & reset;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign valid_out     = valid_q;
   assign wb_data_out   = wb_q;
   assign reg_write_out = rw_out_q;
   assign rd_idx_out    = rd_out_q;
   assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed self-checking bench for mem_stage_dmem_ctrl; timeout checks run when MEM_TIMEOUT_EN is set.
module tb_mem_stage_dmem_ctrl;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [31:0] alu_result_in;
   logic [31:0] rs2_val_in;
   logic        reg_write_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [4:0]  rd_idx_in;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        valid_out;
   logic [31:0] wb_data_out;
   logic        reg_write_out;
   logic [4:0]  rd_idx_out;
   logic        mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage_dmem_ctrl #(
      .XLEN          (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .alu_result_in(alu_result_in),
      .rs2_val_in   (rs2_val_in),
      .reg_write_in (reg_write_in),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .rd_idx_in    (rd_idx_in),
      .mem_stall    (mem_stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .valid_out    (valid_out),
      .wb_data_out  (wb_data_out),
      .reg_write_out(reg_write_out),
      .rd_idx_out   (rd_idx_out),
      .mem_err      (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic rw,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2);
      valid_in      = v;
      mem_read_in   = rd_en;
      mem_write_in  = wr_en;
      reg_write_in  = rw;
      rd_idx_in     = rd;
      alu_result_in = alu;
      rs2_val_in    = rs2;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      reset      = 1'b1;
      #1 reset   = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valid", valid_out, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_wb", wb_data_out, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_rw", reg_write_out, 0);
      chk("rst_rd", rd_idx_out, 0);
      chk("rst_err", mem_err, 0);

      // ALU op retires next cycle without stalling
      cycle(); reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0);
      @(negedge clk);
      chk("add_stall", mem_stall, 0);
      chk("add_valid_early", valid_out, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk("add_valid", valid_out, 1);
      chk("add_wb", wb_data_out, 32'h10);
      chk("add_rd", rd_idx_out, 5);
      chk("add_rw", reg_write_out, 1);
      chk("add_stall2", mem_stall, 0);
      cycle(); @(negedge clk);
      chk("add_valid_drop", valid_out, 0);
      chk("add_wb_hold", wb_data_out, 32'h10);

      // Load, zero-wait bus
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h103, 32'h0);
      @(negedge clk);
      chk("ld_stall", mem_stall, 1);
      chk("ld_req_early", dmem_req, 0);
      cycle(); dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", dmem_we, 0);
      chk("ld_stall_rel", mem_stall, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0); dmem_ready = 1'b0;
      @(negedge clk);
      chk("ld_valid", valid_out, 1);
      chk("ld_wb", wb_data_out, 32'hDEADBEEF);
      chk("ld_rd", rd_idx_out, 7);
      chk("ld_rw", reg_write_out, 1);
      chk("ld_req_drop", dmem_req, 0);

      // Store with three wait cycles
      cycle(); drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h20, 32'hA5A5);
      @(negedge clk);
      chk("st_stall", mem_stall, 1);
      chk("st_req_early", dmem_req, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(); @(negedge clk);
         chk("st_wait_req", dmem_req, 1);
         chk("st_wait_addr", dmem_addr, 32'h20);
         chk("st_wait_wdata", dmem_wdata, 32'hA5A5);
         chk("st_wait_we", dmem_we, 1);
         chk("st_wait_stall", mem_stall, 1);
      end
      cycle(); dmem_ready = 1'b1;
      @(negedge clk);
      chk("st_rdy_req", dmem_req, 1);
      chk("st_rdy_addr", dmem_addr, 32'h20);
      chk("st_rdy_wdata", dmem_wdata, 32'hA5A5);
      chk("st_rdy_stall", mem_stall, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0); dmem_ready = 1'b0;
      @(negedge clk);
      chk("st_valid", valid_out, 1);
      chk("st_rw", reg_write_out, 0);
      chk("st_wb", wb_data_out, 32'h20);
      chk("st_req_drop", dmem_req, 0);
      cycle(); @(negedge clk);
      chk("st_valid_drop", valid_out, 0);
      chk("st_no_reissue", dmem_req, 0);

      // Load to x0 never writes back
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h44, 32'h0);
      @(negedge clk);
      chk("x0_stall", mem_stall, 1);
      cycle(); dmem_ready = 1'b1; dmem_rdata = 32'h1234;
      @(negedge clk);
      chk("x0_req", dmem_req, 1);
      chk("x0_addr", dmem_addr, 32'h44);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0); dmem_ready = 1'b0;
      @(negedge clk);
      chk("x0_valid", valid_out, 1);
      chk("x0_rw", reg_write_out, 0);
      chk("x0_wb", wb_data_out, 32'h1234);

      // Back-to-back load then add; ready left high while idle must be ignored
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h200, 32'h0);
      @(negedge clk);
      chk("b2b_stall", mem_stall, 1);
      cycle(); dmem_ready = 1'b1; dmem_rdata = 32'hCAFE;
      @(negedge clk);
      chk("b2b_req", dmem_req, 1);
      chk("b2b_stall_rel", mem_stall, 0);
      cycle(); drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55, 32'h0); dmem_rdata = 32'hBAD;
      @(negedge clk);
      chk("b2b_ld_valid", valid_out, 1);
      chk("b2b_ld_wb", wb_data_out, 32'hCAFE);
      chk("b2b_ld_rd", rd_idx_out, 2);
      chk("b2b_no_dup_req", dmem_req, 0);
      chk("b2b_add_stall", mem_stall, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0); dmem_ready = 1'b0;
      @(negedge clk);
      chk("b2b_add_valid", valid_out, 1);
      chk("b2b_add_wb", wb_data_out, 32'h55);
      chk("b2b_add_rd", rd_idx_out, 4);
      chk("b2b_req_idle", dmem_req, 0);
      cycle(); @(negedge clk);
      chk("b2b_valid_drop", valid_out, 0);

      // Reset during ACCESS
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0);
      @(negedge clk);
      chk("mr_stall", mem_stall, 1);
      cycle(); @(negedge clk);
      chk("mr_req", dmem_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("mr_req_drop", dmem_req, 0);
      chk("mr_stall_drop", mem_stall, 0);
      chk("mr_valid", valid_out, 0);
      cycle(); reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mr_post_req", dmem_req, 0);
      chk("mr_post_valid", valid_out, 0);
      cycle(); drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h77, 32'h0);
      @(negedge clk);
      chk("mr_idle_stall", mem_stall, 0);
      chk("mr_idle_req", dmem_req, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mr_add_valid", valid_out, 1);
      chk("mr_add_wb", wb_data_out, 32'h77);

`ifdef MEM_TIMEOUT_EN
      // Timeout after 4 ACCESS cycles with ready held low
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h400, 32'h0);
      @(negedge clk);
      chk("to_stall", mem_stall, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(); @(negedge clk);
         chk("to_req", dmem_req, 1);
         chk("to_stall_acc", mem_stall, (i < 3) ? 32'd1 : 32'd0);
         chk("to_err_early", mem_err, 0);
      end
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk("to_req_drop", dmem_req, 0);
      chk("to_err", mem_err, 1);
      chk("to_valid", valid_out, 1);
      chk("to_wb", wb_data_out, 0);
      chk("to_rw", reg_write_out, 0);
      cycle(); @(negedge clk);
      chk("to_err_drop", mem_err, 0);
      chk("to_valid_drop", valid_out, 0);
`else
      // No timeout: ACCESS waits indefinitely, mem_err stays low
      cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h400, 32'h0);
      @(negedge clk);
      chk("nt_stall", mem_stall, 1);
      for (int i = 0; i < 6; i++) begin
         cycle(); @(negedge clk);
         chk("nt_req", dmem_req, 1);
         chk("nt_stall_acc", mem_stall, 1);
         chk("nt_err", mem_err, 0);
      end
      cycle(); dmem_ready = 1'b1; dmem_rdata = 32'h600D;
      @(negedge clk);
      chk("nt_stall_rel", mem_stall, 0);
      cycle(); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0); dmem_ready = 1'b0;
      @(negedge clk);
      chk("nt_valid", valid_out, 1);
      chk("nt_wb", wb_data_out, 32'h600D);
      chk("nt_err_final", mem_err, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
